seq_det_monitor: RTL
====================

# seq_det_monitor

Downstream consumer of the serial sequence detector's `w` output. Converts each detection (rising edge of `w`, however long `w` stays high) into a one-cycle `hit` pulse and keeps a saturating detection count. It measures the gap in clock cycles between consecutive detections and raises a sticky `alarm` when `BURST` detections occur back-to-back with every gap ≤ `MAXGAP`. It runs on the detector's clock and reset, and its outputs feed status/display logic.

## Interface
- `CW`, 8, width of detection counter `count`
- `GW`, 8, width of gap counter/output `gap`
- `BURST`, 3, consecutive close detections that trigger `alarm` (≥2)
- `MAXGAP`, 4, largest gap (cycles) still counted as "close" (≥1, < 2^GW-1)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-low reset
- `w` input 1 — detector output, sampled on `clk`
- `clear` input 1 — synchronous clear of all state/outputs
- `hit` output 1 — one-cycle pulse per detection
- `count` output CW — saturating detection count
- `gap` output GW — cycles between the last two detections
- `gap_vld` output 1 — `gap` holds a valid measurement
- `alarm` output 1 — sticky burst alarm

## Operation
- FSM states: IDLE (w low, no detection yet), BLOCK (w high, not counted), HIGH (w high, counted), LOW (w low, ≥1 detection).
- Transitions: IDLE→HIGH on w=1 (detection); HIGH→LOW on w=0; LOW→HIGH on w=1 (detection); BLOCK→IDLE on w=0; all others hold.
- Detection = entry into HIGH. On detection: `hit`←1 for exactly one cycle; `count`←count+1, held at 2^CW-1 once reached.
- Gap counter `gcnt` (GW bits): loads 1 on detection, otherwise increments each cycle, saturating at 2^GW-1. Runs only in HIGH/LOW.
- On detection from LOW: `gap`←gcnt (pre-edge value), `gap_vld`←1. Detection from IDLE leaves `gap`/`gap_vld` unchanged.
- Run counter: on detection from IDLE → 1. On detection from LOW → run+1 if gcnt ≤ MAXGAP, else 1. Saturates at BURST.
- `alarm` sets on the edge where run becomes BURST. It stays set until `clear` or reset.
- `clear`=1 has priority over all events: every register zeroed, `hit`=0. Next state is BLOCK if w=1, else IDLE. A `w` level held high across `clear` is therefore not recounted.

## Timing
- Reset (rst=0, asynchronous): state IDLE; `hit`=0, `count`=0, `gap`=0, `gap_vld`=0, `alarm`=0; gcnt and run = 0.
- Release of `rst` is synchronous to the next clk edge. No detection happens on the release edge unless w=1 is sampled there, which is then counted from IDLE.
- All outputs are registered. `hit`, `count`, `gap` and `alarm` update on the same edge that samples the detecting `w`=1, so latency is 1 edge.
- `w` high for N cycles produces exactly one `hit`.
- Minimum gap is 2: w=1,0,1 on successive edges.
- `clear` and detection on the same edge: `clear` wins and no count is taken.
- Reset asserted mid-operation: immediate return to reset values, independent of `clk`.

## Configuration
- `SEQ_DET_MONITOR_GAP_EN` defined: gap counter, `gap`, `gap_vld`, run counter and `alarm` are built as above.
- Not defined: that logic is omitted. `gap`, `gap_vld` and `alarm` are tied to 0. FSM, `hit` and `count` are unchanged.

## Test plan
Clock period 200 ns, defaults for all parameters, macro defined unless stated.
- Reset then w held 0 for 10 cycles → all outputs 0, state IDLE.
- w=1 for 3 cycles, then 0 → exactly one `hit` pulse; `count`=1; `gap_vld`=0.
- Detections on edges 0, 3, 6 → gaps 3 and 3; `alarm`=1 on edge 6; `count`=3. Then `clear` → all 0.
- Detections on edges 0, 3, 10, 12 → `gap`=7 then 2; run resets at the 7 gap; `alarm` stays 0.
- `clear` with w=1 held 4 more cycles → no `hit`, `count`=0. Then w 0→1 → `hit`, `count`=1.
- CW=2, 5 detections → `count` sticks at 3. Macro undefined: burst of 3 close detections → `alarm`=0, `gap`=0.

Source files
------------

// File: rtl/seq_det_monitor_if.sv
// Detector-to-monitor status bus: w/clear in, hit/count/gap/alarm status out.
interface seq_det_monitor_if #(
  parameter int unsigned CW = 8,
  parameter int unsigned GW = 8
);
  logic          w;
  logic          clear;
  logic          hit;
  logic [CW-1:0] count;
  logic [GW-1:0] gap;
  logic          gap_vld;
  logic          alarm;

  modport master (output w, clear, input hit, count, gap, gap_vld, alarm);
  modport slave  (input w, clear, output hit, count, gap, gap_vld, alarm);
endinterface

// File: rtl/seq_det_monitor.sv
// Edge-to-pulse monitor for the sequence detector with saturating hit count.
// Gap measurement, burst run tracking and alarm are built only with SEQ_DET_MONITOR_GAP_EN.
module seq_det_monitor #(
  parameter int unsigned CW     = 8,
  parameter int unsigned GW     = 8,
  parameter int unsigned BURST  = 3,
  parameter int unsigned MAXGAP = 4
) (
  input logic              clk,
  input logic              rst,
  seq_det_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BLOCK, HIGH, LOW} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  if (BURST < 2 || MAXGAP < 1 || MAXGAP >= (2 ** GW) - 1) begin : g_bad_cfg
    $error("seq_det_monitor: BURST must be >= 2 and MAXGAP in [1, 2^GW-2]");
  end

  state_t        state;
  state_t        state_nxt;
  logic          det;
  logic          hit_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Detection is entry into HIGH; clear re-arms via BLOCK so a held level is not recounted
  always_comb begin
    state_nxt = state;
    det       = 1'b0;
    if (bus.clear) begin
      state_nxt = bus.w ? BLOCK : IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.w)  begin state_nxt = HIGH; det = 1'b1; end
        BLOCK:   if (!bus.w) state_nxt = IDLE;
        HIGH:    if (!bus.w) state_nxt = LOW;
        LOW:     if (bus.w)  begin state_nxt = HIGH; det = 1'b1; end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      count_q <= '0;
    end else if (bus.clear) begin
      hit_q   <= 1'b0;
      count_q <= '0;
    end else begin
      hit_q <= det;
      if (det && count_q != CNT_MAX) count_q <= count_q + CW'(1);
    end
  end

  assign bus.hit   = hit_q;
  assign bus.count = count_q;

`ifdef SEQ_DET_MONITOR_GAP_EN
  localparam int unsigned   RW       = $clog2(BURST + 1);
  localparam logic [GW-1:0] GCNT_MAX = '1;
  localparam logic [RW-1:0] RUN_MAX  = RW'(BURST);

  logic [GW-1:0] gcnt;
  logic [GW-1:0] gap_q;
  logic          gap_vld_q;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          alarm_q;
  logic          from_low;

  assign from_low = (state == LOW);

  // A close detection extends the run; a first or far detection restarts it at 1
  always_comb begin
    run_nxt = run;
    if (det) begin
      if (from_low && gcnt <= GW'(MAXGAP)) run_nxt = (run == RUN_MAX) ? RUN_MAX : run + RW'(1);
      else                                 run_nxt = RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt      <= '0;
      gap_q     <= '0;
      gap_vld_q <= 1'b0;
      run       <= '0;
      alarm_q   <= 1'b0;
    end else if (bus.clear) begin
      gcnt      <= '0;
      gap_q     <= '0;
      gap_vld_q <= 1'b0;
      run       <= '0;
      alarm_q   <= 1'b0;
    end else begin
      if (det)                                                     gcnt <= GW'(1);
      else if ((state == HIGH || state == LOW) && gcnt != GCNT_MAX) gcnt <= gcnt + GW'(1);
      if (det && from_low) begin
        gap_q     <= gcnt;
        gap_vld_q <= 1'b1;
      end
      run <= run_nxt;
      if (run_nxt == RUN_MAX) alarm_q <= 1'b1;
    end
  end

  assign bus.gap     = gap_q;
  assign bus.gap_vld = gap_vld_q;
  assign bus.alarm   = alarm_q;
`else
  assign bus.gap     = '0;
  assign bus.gap_vld = 1'b0;
  assign bus.alarm   = 1'b0;
`endif
endmodule
